// File: rtl/mem_ctl_exec.sv
// Memory-control executor: queues {addr, data, op} requests in a small FIFO and
// runs each one through FETCH/DECODE/EXECUTE/WB against an internal byte memory.
package MuxParam_pkg;
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    WB      = 2'd3
  } op_codes_e_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    op_e_t      op;
  } mem_ctl_st_t;
endpackage

module mem_ctl_exec
  import MuxParam_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mem_ctl_st_t            req_i,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [7:0]             rsp_addr,
  output logic [7:0]             rsp_data,
  output op_e_t                  rsp_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output op_codes_e_t            phase,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MEM_WORDS);

  mem_ctl_st_t  fifo_q [DEPTH];
  logic [7:0]   mem_q  [MEM_WORDS];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  op_codes_e_t   state_q,  state_d;
  mem_ctl_st_t   cur_q,    cur_d;
  logic [7:0]    rsp_addr_q, rsp_addr_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  op_e_t         rsp_op_q,   rsp_op_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic          push_s;
  logic          pop_s;
  logic          mem_we_s;
  logic          addr_ok_s;
  logic [AW-1:0] mem_idx_s;

  // Ready is a function of occupancy only, so a full FIFO never accepts even on a pop cycle.
  assign req_ready = !rst && (count_q < CW'(DEPTH));
  assign push_s    = req_valid && req_ready;
  assign addr_ok_s = int'(cur_q.addr) < MEM_WORDS;
  assign mem_idx_s = cur_q.addr[AW-1:0];

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rd_ptr_d    = rd_ptr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_valid_d = rsp_valid_q;
    pop_s       = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      FETCH: begin
        if (count_q != '0) begin
          pop_s    = 1'b1;
          cur_d    = fifo_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PW'(1);
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        rsp_addr_d  = cur_q.addr;
        rsp_op_d    = cur_q.op;
        rsp_valid_d = 1'b1;
        // Out-of-range addresses drop writes and read back as zero.
        if (cur_q.op == WR) begin
          rsp_data_d = cur_q.data;
          mem_we_s   = addr_ok_s;
        end else begin
          rsp_data_d = addr_ok_s ? mem_q[mem_idx_s] : 8'd0;
        end
        state_d = WB;
      end
      WB: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = FETCH;
        end else begin
          state_d     = WB;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      cur_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_addr_q  <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_op_q    <= RD;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= req_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (mem_we_s) begin
      mem_q[mem_idx_s] <= cur_q.data;
    end
  end

  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign phase      = state_q;
  assign fifo_count = count_q;

endmodule
